// File: rtl/imem_write_arbiter.sv
// imem_write_arbiter
// Shares the single instruction-memory write port between the boot loader
// (requester 0) and the CPU/debug store path (requester 1). One write is
// accepted at a time, registered, and held on the memory port until the
// memory handshakes. Requester 1 is masked until boot_done is high.
//
// Optional feature: define IMEM_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking. Without it, requester 0 always wins when both are eligible.

module imem_write_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  boot_done,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  output logic                  grant_id,
  output logic                  busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0] state;
  logic       elig0;
  logic       elig1;
  logic       any_elig;
  logic       winner;

`ifdef IMEM_ARB_ROUND_ROBIN_EN
  logic       last_grant;
`endif

  // Decide which requester would win the port if a grant happened this cycle
  always_comb begin
    elig0    = req0_valid;
    elig1    = req1_valid & boot_done;
    any_elig = elig0 | elig1;
    winner   = 1'b0;
    if (elig0 && elig1) begin
`ifdef IMEM_ARB_ROUND_ROBIN_EN
      winner = ~last_grant;
`else
      winner = 1'b0;
`endif
    end else begin
      winner = elig1;
    end
  end

  // Main control: accept one write in IDLE, hold it in ISSUE until mem_ready
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      grant_id   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_elig) begin
            state      <= ST_ISSUE;
            mem_valid  <= 1'b1;
            mem_addr   <= winner ? req1_addr : req0_addr;
            mem_data   <= winner ? req1_data : req0_data;
            req0_ready <= ~winner;
            req1_ready <= winner;
            grant_id   <= winner;
          end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
          end
        end
        ST_ISSUE: begin
          req0_ready <= 1'b0;
          req1_ready <= 1'b0;
          if (mem_ready) begin
            state     <= ST_IDLE;
            mem_valid <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          mem_valid  <= 1'b0;
          req0_ready <= 1'b0;
          req1_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMEM_ARB_ROUND_ROBIN_EN
  // Remember who was granted last so ties alternate; starts at 1 to favour the loader
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (state == ST_IDLE && any_elig) begin
      last_grant <= winner;
    end
  end
`endif

  assign busy = (state == ST_ISSUE);

endmodule

// File: tb/tb_imem_write_arbiter.sv
// tb_imem_write_arbiter
// Directed bench for imem_write_arbiter with a transaction-level model that
// is compared against the DUT on every falling edge once reset has been seen.
// Honours IMEM_ARB_ROUND_ROBIN_EN for the contention expectations.

module tb_imem_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        boot_done;
  logic        req0_valid;
  logic [31:0] req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        grant_id;
  logic        busy;

  int tests = 0;
  int fails = 0;

  imem_write_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .boot_done(boot_done),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .grant_id(grant_id), .busy(busy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // ---------------- transaction model ----------------
  // The model holds "the write currently owed to memory" plus the accept
  // pulses produced this cycle; arbitration comes from a function.
  logic        model_valid = 1'b0;
  logic        m_pending;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic        m_ack0;
  logic        m_ack1;
  logic        m_gid;
  logic        m_lg;

  // Returns {someone_wins, who_wins} for the given eligibility
  function automatic logic [1:0] arbitrate(input logic e0, input logic e1, input logic lg);
    if (!e0 && !e1) return 2'b00;
    if (e0 && e1) begin
`ifdef IMEM_ARB_ROUND_ROBIN_EN
      return {1'b1, ~lg};
`else
      return {1'b1, 1'b0 & lg};
`endif
    end
    return {1'b1, e1};
  endfunction

  logic [1:0] m_pick;
  assign m_pick = arbitrate(req0_valid, req1_valid & boot_done, m_lg);

  // Advance the model on each rising edge from the inputs seen at that edge
  always @(posedge clk) begin
    if (reset) begin
      model_valid <= 1'b1;
      m_pending   <= 1'b0;
      m_addr      <= 32'h0;
      m_data      <= 32'h0;
      m_ack0      <= 1'b0;
      m_ack1      <= 1'b0;
      m_gid       <= 1'b0;
      m_lg        <= 1'b1;
    end else if (m_pending) begin
      m_ack0 <= 1'b0;
      m_ack1 <= 1'b0;
      if (mem_ready) m_pending <= 1'b0;
    end else if (m_pick[1]) begin
      m_pending <= 1'b1;
      m_addr    <= m_pick[0] ? req1_addr : req0_addr;
      m_data    <= m_pick[0] ? req1_data : req0_data;
      m_ack0    <= !m_pick[0];
      m_ack1    <= m_pick[0];
      m_gid     <= m_pick[0];
      m_lg      <= m_pick[0];
    end else begin
      m_ack0 <= 1'b0;
      m_ack1 <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("mdl_mem_valid", mem_valid, m_pending);
      checkOutput("mdl_req0_ready", req0_ready, m_ack0);
      checkOutput("mdl_req1_ready", req1_ready, m_ack1);
      checkOutput("mdl_grant_id", grant_id, m_gid);
      checkOutput("mdl_busy", busy, m_pending);
      checkOutput("mdl_mem_addr", mem_addr, m_addr);
      checkOutput("mdl_mem_data", mem_data, m_data);
      checkOutput("both_ready", req0_ready & req1_ready, 1'b0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic bd, input logic v0, input logic [31:0] a0,
                               input logic [31:0] d0, input logic v1, input logic [31:0] a1,
                               input logic [31:0] d1, input logic mr);
    boot_done  = bd;
    req0_valid = v0;
    req0_addr  = a0;
    req0_data  = d0;
    req1_valid = v1;
    req1_addr  = a1;
    req1_data  = d1;
    mem_ready  = mr;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_mem_valid"}, mem_valid, 1'b0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
    checkOutput({tag, "_mem_data"}, mem_data, 32'h0);
    checkOutput({tag, "_req0_ready"}, req0_ready, 1'b0);
    checkOutput({tag, "_req1_ready"}, req1_ready, 1'b0);
    checkOutput({tag, "_grant_id"}, grant_id, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
  endtask

  int exp_grants[8];
  int got_grants[8];
  int n_grants;
  int cycles_used;

  initial begin
`ifdef IMEM_ARB_ROUND_ROBIN_EN
    exp_grants = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_grants = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif

    // Reset
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    step();
    step();
    checkResetValues("reset");
    reset = 1'b0;

    // Masking: req1 ignored while boot_done is low
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("mask_req1_ready", req1_ready, 1'b0);
      checkOutput("mask_mem_valid", mem_valid, 1'b0);
    end
    boot_done = 1'b1;
    step();
    checkOutput("unmask_req1_ready", req1_ready, 1'b1);
    checkOutput("unmask_mem_addr", mem_addr, 32'h40);
    checkOutput("unmask_mem_data", mem_data, 32'hDEADBEEF);
    checkOutput("unmask_grant_id", grant_id, 1'b1);
    req1_valid = 1'b0;
    step();
    checkOutput("unmask_done", mem_valid, 1'b0);
    checkOutput("unmask_pulse_once", req1_ready, 1'b0);

    // Single write latency with mem_ready tied high
    applyStimulus(1'b1, 1'b1, 32'h0, 32'h12345678, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    checkOutput("lat_req0_ready", req0_ready, 1'b1);
    checkOutput("lat_mem_valid", mem_valid, 1'b1);
    checkOutput("lat_mem_data", mem_data, 32'h12345678);
    req0_valid = 1'b0;
    step();
    checkOutput("lat_mem_valid_clr", mem_valid, 1'b0);
    checkOutput("lat_req0_ready_clr", req0_ready, 1'b0);

    // Back-pressure: payload held, no accepts while memory stalls
    applyStimulus(1'b1, 1'b1, 32'h100, 32'hA5A5A5A5, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    checkOutput("bp_accept", req0_ready, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h104, 32'h11111111, 1'b1, 32'h200, 32'h5A5A5A5A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("bp_mem_valid", mem_valid, 1'b1);
      checkOutput("bp_mem_addr", mem_addr, 32'h100);
      checkOutput("bp_mem_data", mem_data, 32'hA5A5A5A5);
      checkOutput("bp_no_ready", {req0_ready, req1_ready}, 2'b00);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    checkOutput("bp_release", mem_valid, 1'b0);
    step();

    // Contention from a fresh reset so tie-breaking starts in a known state
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h1000, 32'hA0000000, 1'b1, 32'h2000, 32'hB0000000, 1'b1);
    n_grants = 0;
    cycles_used = 0;
    while (n_grants < 8 && cycles_used < 40) begin
      step();
      cycles_used++;
      if (req0_ready && n_grants < 8) begin
        got_grants[n_grants] = 0;
        n_grants++;
        req0_addr = req0_addr + 32'd4;
        req0_data = req0_data + 32'd1;
      end
      if (req1_ready && n_grants < 8) begin
        got_grants[n_grants] = 1;
        n_grants++;
        req1_addr = req1_addr + 32'd4;
        req1_data = req1_data + 32'd1;
      end
    end
    checkOutput("cont_grant_count", n_grants, 8);
    checkOutput("cont_cycles", cycles_used, 15);
    for (int i = 0; i < n_grants; i++) begin
      checkOutput($sformatf("cont_grant_%0d", i), got_grants[i], exp_grants[i]);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    step();

    // Reset while a write is stalled in ISSUE
    applyStimulus(1'b1, 1'b1, 32'h300, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    checkOutput("rmid_accept", req0_ready, 1'b1);
    req0_valid = 1'b0;
    step();
    checkOutput("rmid_busy", busy, 1'b1);
    reset = 1'b1;
    step();
    checkResetValues("rmid");
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h304, 32'h0BADC0DE, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    checkOutput("rmid_fresh_ready", req0_ready, 1'b1);
    checkOutput("rmid_fresh_valid", mem_valid, 1'b1);
    checkOutput("rmid_fresh_addr", mem_addr, 32'h304);
    req0_valid = 1'b0;
    step();
    checkOutput("rmid_fresh_done", mem_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
